foo_in_arbiter: RTL and testbench
=================================

Name: foo_in_arbiter

Overview:
- Shares the single foo datapath input port (test_in_valid/test_in) between NUM_REQ requesters using round-robin arbitration with valid/ready handshakes.
- Records the granted requester ID in an in-order tag FIFO. Each test_out_valid pops the oldest tag and routes test_out back to that requester.
- Limits in-flight transactions to MAX_OUTSTANDING.
- foo produces exactly one output per input, in order, with latency >= 1 cycle and no backpressure.

Parameters:
- NUM_REQ, default 4: number of requesters, 2..16. Derived TAG_W = $clog2(NUM_REQ).
- MAX_OUTSTANDING, default 8: tag FIFO depth and credit limit. Must be a power of 2, 2..64.
- TIMEOUT, default 256: watchdog cycles, used only when FOO_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_data  in  NUM_REQ*8  requester i data in bits [8i+7:8i]
- req_ready  out  NUM_REQ  per-requester grant/ready, combinational
- test_in_valid  out  1  foo input valid, registered
- test_in  out  8  foo input data, registered
- test_out_valid  in  1  foo output valid
- test_out  in  8  foo output data
- rsp_valid  out  NUM_REQ  one-hot response strobe, registered
- rsp_data  out  8  response data, registered, shared by all requesters
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight count
- err_orphan  out  1  sticky: test_out_valid seen with tag FIFO empty
- err_timeout  out  1  sticky watchdog error; tied 0 when the macro is undefined

Behaviour:
- Reset (asynchronous, reset_n=0):
  - test_in_valid, test_in, rsp_valid, rsp_data, outstanding, err_orphan and err_timeout all go to 0.
  - Tag FIFO is emptied; round-robin pointer goes to 0 (requester 0 has highest priority first).
  - req_ready is 0 while reset_n=0.
- Credit: can_issue = (outstanding < MAX_OUTSTANDING). There is no same-cycle bypass: when outstanding == MAX, all req_ready are 0 even if a pop occurs in that cycle.
- Arbitration (combinational, each cycle):
  - When can_issue is true, search req_valid starting at index (last_grant+1) mod NUM_REQ.
  - The first requester found gets req_ready[i]=1; all other ready bits are 0.
  - req_ready[i] never asserts without req_valid[i].
- Transfer (req_valid[i] & req_ready[i] at edge t):
  - At t+1: test_in_valid=1 and test_in=req_data[i].
  - Tag i is pushed at edge t.
  - last_grant updates to i only on a transfer.
  - test_in_valid is 0 in cycles with no transfer; at most one issue per cycle (full throughput).
- Response (test_out_valid=1 at edge t):
  - If the FIFO is non-empty, pop tag k.
  - At t+1: rsp_valid is one-hot at bit k and rsp_data=test_out. rsp_valid is 0 otherwise; rsp_data holds its last value.
  - Responses cannot be refused.
- Orphan: test_out_valid with the FIFO empty (including an empty FIFO with a push in the same cycle) sets err_orphan=1. The beat is dropped, no rsp_valid, and outstanding is unchanged. err_orphan clears only on reset.
- outstanding counter:
  - +1 on transfer, -1 on pop.
  - Unchanged when a transfer and a pop occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING; FIFO read/write pointers wrap modulo depth.
- Reset mid-operation: in-flight tags are discarded. Any test_out_valid arriving after reset with the FIFO empty is an orphan.

Optional Feature:
- Macro: FOO_ARB_TIMEOUT_EN.
- When defined:
  - A watchdog counter increments each cycle while outstanding>0 and test_out_valid=0.
  - It clears on any pop and whenever outstanding==0.
  - On reaching TIMEOUT: err_timeout=1 (sticky until reset), the tag FIFO is flushed, outstanding goes to 0, and the counter clears.
  - Arbitration resumes the next cycle.
- When undefined: no watchdog logic; err_timeout is tied 0.

Test Plan:
- Single request: req_valid[2]=1, req_data[23:16]=0x5A; foo model with latency 3 returning in+1. Required: req_ready[2]=1 in the same cycle; test_in_valid=1 with test_in=0x5A one cycle later; rsp_valid=4'b0100 with rsp_data=0x5B; outstanding goes 0->1->0.
- Fairness: all four requesters hold req_valid continuously. Required: grant order 0,1,2,3,0,1,... with one test_in_valid per cycle; each rsp_valid bit returns to the matching requester in issue order.
- Credit full: foo model stalls outputs and requester 0 streams. Required: after 8 transfers outstanding=8 and req_ready=0. One test_out_valid gives outstanding=7, and exactly one more grant follows on the next cycle.
- Simultaneous transfer and pop at outstanding=5: required outstanding stays 5 and tag order is preserved.
- Orphan: test_out_valid=1 with test_out=0x33 after reset and no requests. Required: err_orphan=1 next cycle, rsp_valid=0, outstanding=0.
- Reset mid-flight with 5 outstanding: required all outputs at 0 immediately. A late test_out_valid sets err_orphan. With FOO_ARB_TIMEOUT_EN and TIMEOUT=16, stalling foo with 3 outstanding gives err_timeout=1 after 16 cycles and outstanding=0.

Source files
------------

// File: rtl/foo_in_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : foo_in_arbiter
// Brief    : Round-robin arbiter that shares the foo datapath input between
//            NUM_REQ requesters. An in-order tag FIFO routes each foo output
//            back to the requester that issued it. The number of in-flight
//            transactions is limited to MAX_OUTSTANDING.
//            Optional watchdog: define FOO_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module foo_in_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT         = 256
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*8-1:0]                 req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 test_in_valid,
    output logic [7:0]                           test_in,
    input  logic                                 test_out_valid,
    input  logic [7:0]                           test_out,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [7:0]                           rsp_data,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 err_orphan,
    output logic                                 err_timeout
);

    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
    localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_OUTSTANDING);

    // Elaboration-time parameter range guard
    generate
        if ((NUM_REQ < 2) || (NUM_REQ > 16) ||
            (MAX_OUTSTANDING < 2) || (MAX_OUTSTANDING > 64) ||
            ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) ||
            (TIMEOUT < 1)) begin : g_param_check
            $error("foo_in_arbiter: illegal parameter value");
        end
    endgenerate

    logic [TAG_W-1:0]   r_rr_ptr;     // first index searched next cycle
    logic [TAG_W-1:0]   r_tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_err_orphan;

    logic               w_can_issue;
    logic               w_grant_found;
    logic [TAG_W-1:0]   w_grant_idx;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_orphan;
    logic               w_empty;
    logic [NUM_REQ-1:0] w_rsp_onehot;
    logic               w_wd_fire;

    // No bypass: a pop in the same cycle does not free a credit until next cycle.
    // The watchdog flush cycle also blocks issue so arbitration restarts cleanly.
    assign w_can_issue = (r_count < c_max_cnt) && !w_wd_fire;
    assign w_empty     = (r_count == '0);
    assign w_pop       = test_out_valid && !w_empty;
    assign w_orphan    = test_out_valid && w_empty;
    assign w_push      = w_can_issue && w_grant_found;

    // Round-robin search starting at r_rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        logic [TAG_W:0] v_idx;
        v_idx         = '0;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_ready       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = {1'b0, r_rr_ptr} + (TAG_W+1)'(k);
            if (v_idx >= (TAG_W+1)'(NUM_REQ)) begin
                v_idx = v_idx - (TAG_W+1)'(NUM_REQ);
            end
            if (!w_grant_found && req_valid[v_idx[TAG_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = v_idx[TAG_W-1:0];
            end
        end
        if (w_can_issue && w_grant_found) begin
            w_ready[w_grant_idx] = 1'b1;
        end
    end

    assign req_ready = reset_n ? w_ready : '0;

    // Decode the oldest tag into the response strobe
    always_comb begin
        w_rsp_onehot = '0;
        w_rsp_onehot[r_tag_mem[r_rd_ptr]] = 1'b1;
    end

    // Tag storage: contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= w_grant_idx;
        end
    end

    // FIFO pointers and in-flight count; a watchdog flush discards all tags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_wd_fire) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Round-robin pointer moves past the winner only on a real transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
        end else if (w_push) begin
            r_rr_ptr <= (w_grant_idx == TAG_W'(NUM_REQ-1)) ? '0 : w_grant_idx + TAG_W'(1);
        end
    end

    // Registered foo input and requester response outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            test_in_valid <= 1'b0;
            test_in       <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
        end else begin
            test_in_valid <= w_push;
            if (w_push) begin
                test_in <= req_data[{w_grant_idx, 3'b000} +: 8];
            end
            rsp_valid <= w_pop ? w_rsp_onehot : '0;
            if (w_pop) begin
                rsp_data <= test_out;
            end
        end
    end

    // Sticky flag for foo outputs that have no matching tag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_orphan <= 1'b0;
        end else if (w_orphan) begin
            r_err_orphan <= 1'b1;
        end
    end

    assign outstanding = r_count;
    assign err_orphan  = r_err_orphan;

`ifdef FOO_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT+1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err_timeout;
    logic            w_wd_inc;

    // Count stalled cycles; any response or an idle arbiter clears the count
    assign w_wd_inc  = !w_empty && !test_out_valid;
    assign w_wd_fire = w_wd_inc && (r_wd_cnt == WD_W'(TIMEOUT-1));

    // Watchdog counter and sticky timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wd_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else if (w_wd_fire) begin
            r_wd_cnt      <= '0;
            r_err_timeout <= 1'b1;
        end else if (w_wd_inc) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end else begin
            r_wd_cnt <= '0;
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_wd_fire   = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_foo_in_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_foo_in_arbiter
// Brief    : Self-checking bench for foo_in_arbiter (default build). Table
//            vectors, hand sequences for credit/reset corners, and a random
//            phase against a queue-based reference model with a foo model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_foo_in_arbiter;

    localparam int NREQ = 4;
    localparam int MAXO = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        test_in_valid;
    logic [7:0]  test_in;
    logic        test_out_valid = 1'b0;
    logic [7:0]  test_out = '0;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic [3:0]  outstanding;
    logic        err_orphan;
    logic        err_timeout;

    foo_in_arbiter #(.NUM_REQ(NREQ), .MAX_OUTSTANDING(MAXO), .TIMEOUT(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .test_in_valid  (test_in_valid),
        .test_in        (test_in),
        .test_out_valid (test_out_valid),
        .test_out       (test_out),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .outstanding    (outstanding),
        .err_orphan     (err_orphan),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: issued-but-unanswered requester IDs in order
    int         q_tag[$];
    int         m_ptr;
    logic       m_orphan;
    logic       e_tiv;
    logic [7:0] e_ti;
    logic [3:0] e_rsp;
    logic [7:0] e_rd;

    typedef struct {
        logic [3:0] rv;
        logic       tov;
        logic [7:0] to;
        logic [3:0] ready;
        logic [3:0] rsp;
        logic [3:0] outs;
    } vec_t;

    typedef struct {
        int         due;
        logic [7:0] d;
    } foo_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called in the drive window (just after a rising edge); returns there.
    task automatic cycle(input logic [3:0] rv, input logic tov, input logic [7:0] to,
                         output logic [3:0] obs_ready);
        logic [3:0] er;
        int         g;
        int         idx;
        req_valid      = rv;
        test_out_valid = tov;
        test_out       = to;
        er = '0;
        g  = -1;
        if (q_tag.size() < MAXO) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && rv[idx]) g = idx;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        #3;
        obs_ready = req_ready;
        chk("req_ready", {28'd0, req_ready}, {28'd0, er});
        @(posedge clk);
        if (tov) begin
            if (q_tag.size() == 0) begin
                m_orphan = 1'b1;
                e_rsp    = '0;
            end else begin
                e_rsp    = 4'(1 << q_tag.pop_front());
                e_rd     = to;
            end
        end else begin
            e_rsp = '0;
        end
        if (g >= 0) begin
            q_tag.push_back(g);
            m_ptr = (g + 1) % NREQ;
            e_tiv = 1'b1;
            e_ti  = req_data[g*8 +: 8];
        end else begin
            e_tiv = 1'b0;
        end
        #1;
        chk("test_in_valid", {31'd0, test_in_valid}, {31'd0, e_tiv});
        if (e_tiv) chk("test_in", {24'd0, test_in}, {24'd0, e_ti});
        chk("rsp_valid", {28'd0, rsp_valid}, {28'd0, e_rsp});
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, e_rd});
        chk("outstanding", {28'd0, outstanding}, 32'(q_tag.size()));
        chk("err_orphan", {31'd0, err_orphan}, {31'd0, m_orphan});
        chk("err_timeout", {31'd0, err_timeout}, 32'd0);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_test_in_valid", {31'd0, test_in_valid}, 32'd0);
        chk("rst_test_in", {24'd0, test_in}, 32'd0);
        chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("rst_outstanding", {28'd0, outstanding}, 32'd0);
        chk("rst_err_orphan", {31'd0, err_orphan}, 32'd0);
        chk("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
        q_tag.delete();
        m_ptr = 0; m_orphan = 1'b0;
        e_tiv = 1'b0; e_ti = '0; e_rsp = '0; e_rd = '0;
        req_valid = '0; test_out_valid = 1'b0; test_out = '0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        vec_t       tbl[15];
        foo_t       fq[$];
        logic [3:0] obs;
        int         cyc;
        int         last_due;
        int         due;
        int         lat;
        logic       tv;
        logic [7:0] tdat;

        // rv, tov, to, expected ready, expected rsp_valid, expected outstanding
        tbl[0]  = '{4'b0100, 1'b0, 8'h00, 4'b0100, 4'b0000, 4'd1};
        tbl[1]  = '{4'b0000, 1'b0, 8'h00, 4'b0000, 4'b0000, 4'd1};
        tbl[2]  = '{4'b0000, 1'b0, 8'h00, 4'b0000, 4'b0000, 4'd1};
        tbl[3]  = '{4'b0000, 1'b1, 8'h5B, 4'b0000, 4'b0100, 4'd0};
        tbl[4]  = '{4'b1111, 1'b0, 8'h00, 4'b1000, 4'b0000, 4'd1};
        tbl[5]  = '{4'b1111, 1'b0, 8'h00, 4'b0001, 4'b0000, 4'd2};
        tbl[6]  = '{4'b1111, 1'b0, 8'h00, 4'b0010, 4'b0000, 4'd3};
        tbl[7]  = '{4'b1111, 1'b1, 8'h77, 4'b0100, 4'b1000, 4'd3};
        tbl[8]  = '{4'b1010, 1'b1, 8'h78, 4'b1000, 4'b0001, 4'd3};
        tbl[9]  = '{4'b0110, 1'b1, 8'h79, 4'b0010, 4'b0010, 4'd3};
        tbl[10] = '{4'b0000, 1'b1, 8'h7A, 4'b0000, 4'b0100, 4'd2};
        tbl[11] = '{4'b0001, 1'b1, 8'h7B, 4'b0001, 4'b1000, 4'd2};
        tbl[12] = '{4'b0000, 1'b1, 8'h7C, 4'b0000, 4'b0010, 4'd1};
        tbl[13] = '{4'b0000, 1'b1, 8'h7D, 4'b0000, 4'b0001, 4'd0};
        tbl[14] = '{4'b0000, 1'b1, 8'h33, 4'b0000, 4'b0000, 4'd0};

        do_reset();
        req_data = {8'hD4, 8'h5A, 8'hB2, 8'hA1};
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].rv, tbl[i].tov, tbl[i].to, obs);
            chk("tbl_ready", {28'd0, obs}, {28'd0, tbl[i].ready});
            chk("tbl_rsp_valid", {28'd0, rsp_valid}, {28'd0, tbl[i].rsp});
            chk("tbl_outstanding", {28'd0, outstanding}, {28'd0, tbl[i].outs});
        end
        chk("tbl_orphan", {31'd0, err_orphan}, 32'd1);

        // Orphan straight after reset
        do_reset();
        cycle(4'b0000, 1'b1, 8'h33, obs);
        chk("orphan_flag", {31'd0, err_orphan}, 32'd1);
        chk("orphan_rsp", {28'd0, rsp_valid}, 32'd0);
        chk("orphan_outstanding", {28'd0, outstanding}, 32'd0);

        // Credit limit: no same-cycle bypass when a pop frees a slot
        do_reset();
        for (int i = 0; i < 8; i++) cycle(4'b0001, 1'b0, 8'h00, obs);
        chk("credit_cnt8", {28'd0, outstanding}, 32'd8);
        cycle(4'b0001, 1'b1, 8'h44, obs);
        chk("credit_full_ready", {28'd0, obs}, 32'd0);
        chk("credit_cnt7", {28'd0, outstanding}, 32'd7);
        cycle(4'b0001, 1'b0, 8'h00, obs);
        chk("credit_regrant", {28'd0, obs}, 32'd1);
        chk("credit_cnt8b", {28'd0, outstanding}, 32'd8);
        cycle(4'b0001, 1'b0, 8'h00, obs);
        chk("credit_full_again", {28'd0, obs}, 32'd0);
        for (int i = 0; i < 8; i++) cycle(4'b0000, 1'b1, 8'(8'h60 + i), obs);
        chk("credit_drained", {28'd0, outstanding}, 32'd0);

        // Simultaneous transfer and pop at five outstanding, then reset mid-flight
        for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b0, 8'h00, obs);
        cycle(4'b1111, 1'b1, 8'hC3, obs);
        chk("simul_cnt5", {28'd0, outstanding}, 32'd5);
        req_valid = 4'b1111;
        #2;
        do_reset();
        cycle(4'b0000, 1'b1, 8'h99, obs);
        chk("late_orphan", {31'd0, err_orphan}, 32'd1);
        chk("late_rsp", {28'd0, rsp_valid}, 32'd0);

        // Random traffic with an in-order foo model of variable latency
        do_reset();
        cyc = 0;
        last_due = -1;
        for (int n = 0; n < 800; n++) begin
            if (test_in_valid) begin
                lat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 20))
                                                  : int'($urandom_range(1, 4));
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                fq.push_back('{due, 8'(test_in + 8'd1)});
            end
            tv   = 1'b0;
            tdat = 8'($urandom());
            if (fq.size() > 0 && fq[0].due <= cyc) begin
                tv   = 1'b1;
                tdat = fq[0].d;
                void'(fq.pop_front());
            end
            req_data = $urandom();
            cycle(4'($urandom_range(0, 15)), tv, tdat, obs);
            cyc++;
        end
        chk("random_no_orphan", {31'd0, err_orphan}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
